// File: rtl/par2ser.sv
//------------------------------------------------------------------------------
// par2ser : W-bit words in on valid/ready, LSB-first serial out gated by ser_en.
// Optional one-word holding register for zero-bubble streaming: PAR2SER_SKID_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module par2ser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] par_din,
  input  logic         par_din_valid,
  output logic         par_din_ready,
  input  logic         ser_en,
  output logic         ser_dout,
  output logic         ser_dout_valid,
  output logic         busy
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_SHIFT  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_next;
  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_word_end;
  logic          w_load_direct;
  logic          w_refill;

`ifdef PAR2SER_SKID_EN
  logic [W-1:0]  r_hold;
  logic          r_hold_v;
  logic          w_load_hold;
  logic          w_reload;

  assign par_din_ready = rstn & ~r_hold_v;
  // A word end keeps SHIFT when another word is ready to follow immediately.
  assign w_refill      = r_hold_v | w_accept;
`else
  assign par_din_ready = rstn & (r_state == S_IDLE);
  assign w_refill      = 1'b0;
`endif

  assign w_accept   = par_din_valid & par_din_ready;
  assign w_word_end = (r_state == S_SHIFT) & ser_en & (r_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
      S_SHIFT: if (w_word_end & ~w_refill) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
`ifdef PAR2SER_SKID_EN
    w_load_direct = w_accept & ((r_state == S_IDLE) | (w_word_end & ~r_hold_v));
    w_load_hold   = w_accept & ~w_load_direct;
    w_reload      = w_word_end & r_hold_v;
`else
    w_load_direct = w_accept;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg        <= '0;
      r_cnt          <= '0;
      ser_dout       <= 1'b0;
      ser_dout_valid <= 1'b0;
    end else begin
      ser_dout_valid <= 1'b0;
      if (busy && ser_en) begin
        ser_dout       <= r_shreg[r_cnt];
        ser_dout_valid <= 1'b1;
        r_cnt          <= w_word_end ? '0 : r_cnt + 1'b1;
      end
      if (w_load_direct) begin
        r_shreg <= par_din;
        r_cnt   <= '0;
      end
`ifdef PAR2SER_SKID_EN
      else if (w_reload) begin
        r_shreg <= r_hold;
        r_cnt   <= '0;
      end
`endif
    end
  end

`ifdef PAR2SER_SKID_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else if (w_load_hold) begin
      r_hold   <= par_din;
      r_hold_v <= 1'b1;
    end else if (w_reload) begin
      r_hold_v <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire
